modn_updown_counter: RTL and testbench
======================================

// Module: modn_updown_counter
// PURPOSE
//  Parametrised mod-N synchronous up/down counter; general successor to the fixed mod-7 T-flip-flop counter.
//  Counts 0..MODULUS-1 in either direction, with synchronous clear, parallel load, enable and one-shot mode.
//  Wraps cleanly with no illegal transient state; has a terminal-count pulse and a cascade carry for chaining stages.
//  Used as the common counter for lab dividers, timers and sequencers.
// PARAMETERS
//  MODULUS   7                                Count modulus, >=2; legal count range 0..MODULUS-1
//  WIDTH     (MODULUS>2)?$clog2(MODULUS):1    Local derived count width, not overridable
//  ONE_SHOT  0                                Reset value of the one-shot mode enable
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      reset, asynchronous, active-high
//  en         in   1      count enable
//  up_dn      in   1      1 = count up, 0 = count down; sampled each enabled edge
//  clr        in   1      synchronous clear to 0
//  load       in   1      synchronous parallel load
//  load_val   in   WIDTH  value to load
//  one_shot   in   1      1 = stop at terminal count (done), 0 = free-run/wrap
//  count      out  WIDTH  current count, registered
//  tc         out  1      registered 1-cycle pulse, high the cycle after a wrap edge
//  carry_out  out  1      combinational: en & ~done & count==terminal(up_dn); drives next stage en
//  done       out  1      one-shot finished flag, sticky
//  load_err   out  1      registered 1-cycle pulse: load_val >= MODULUS was clamped
// BEHAVIOUR
//  Reset: count=0, tc=0, done=0, load_err=0; asynchronous, effective regardless of clk.
//  Priority per edge: clr > load > en.
//   - clr: count<=0, done<=0.
//   - load: count<=min(load_val, MODULUS-1), done<=0; load_err<=1 if clamped.
//   - en & ~done: count steps by 1 in the up_dn direction.
//  Up: MODULUS-1 -> 0 wraps, tc<=1. Down: 0 -> MODULUS-1 wraps, tc<=1.
//  Latency: count changes on the first edge where en=1; tc/load_err follow one cycle after their cause edge.
//  One-shot (one_shot=1): at the terminal value with en=1, count holds and done<=1; no wrap, tc<=1 once.
//   - While done=1, en is ignored and carry_out=0.
//  tc, load_err default 0 every edge unless set; never high for more than 1 cycle per event.
//  up_dn change at the terminal value: terminal is re-evaluated that same cycle, so no spurious wrap.
//  clr or load in the same cycle as a wrap: clr/load wins; tc stays 0.
//  Changing one_shot mid-count takes effect next edge; clearing one_shot does not clear done (only clr/load/rst).
//  rst mid-count: all outputs to reset values immediately; first edge after deassert counts normally.
//  Count arithmetic is WIDTH bits, computed against MODULUS-1; count never leaves 0..MODULUS-1.
//  This holds even when MODULUS is not a power of two.
// STRUCTURE
//  Shared package counter_pkg: function clog2_min1(), direction constants CNT_UP=1'b1 / CNT_DN=1'b0.
//  Sub-module modn_next_state: combinational; inputs count, up_dn, MODULUS; outputs next, at_term.
//   - Isolates wrap arithmetic.
//   - Top holds registers, priority mux, done/tc/load_err flags.
//  Cascaded stages: chain carry_out of stage k to en of stage k+1; all stages share clk/rst.
// TESTING
//  1. MODULUS=7, up, en=1 for 10 clks from reset.
//     -> count 1,2,3,4,5,6,0,1,2,3; tc high exactly once, the cycle after 6->0.
//  2. MODULUS=7, down from 0: en=1, up_dn=0.
//     -> count 6,5,4; tc pulse after the 0->6 edge; carry_out high only while count==0.
//  3. load=1, load_val=5 -> count=5, load_err=0.
//     load_val=7 (MODULUS=7) -> count=6, load_err 1-cycle pulse.
//     clr+load same edge -> count=0.
//  4. one_shot=1, up, from 4, MODULUS=7 -> 5,6 then holds 6, done=1, single tc.
//     Further en ignored; clr -> count=0, done=0.
//  5. Two cascaded MODULUS=10 stages, 100 enabled clks from reset.
//     -> high stage 9 -> 0 wrap; combined value 00 at end; low stage carry_out drives exactly 10 high-stage steps.
//  6. Assert rst asynchronously mid-count at count=3, between edges.
//     -> count=0, flags 0 before next edge; MODULUS=2 and MODULUS=16 regressions pass scenario 1.

Source files
------------

// File: rtl/modn_updown_counter_pkg.sv
// Shared definitions for the mod-N up/down counter: direction encodings and
// the width helper that keeps a mod-2 counter at one bit.
package modn_updown_counter_pkg;

    localparam logic CNT_UP = 1'b1;
    localparam logic CNT_DN = 1'b0;

    // Count width for a given modulus; never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/modn_updown_counter_if.sv
// Control and status bundle of one counter stage. The master drives the
// controls and observes the status; the counter itself is the slave.
interface modn_updown_counter_if #(
    parameter int MODULUS = 7
);
    localparam int WIDTH = modn_updown_counter_pkg::clog2_min1(MODULUS);

    logic             en;
    logic             up_dn;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             one_shot;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             carry_out;
    logic             done;
    logic             load_err;

    modport master (
        output en, up_dn, clr, load, load_val, one_shot,
        input  count, tc, carry_out, done, load_err
    );

    modport slave (
        input  en, up_dn, clr, load, load_val, one_shot,
        output count, tc, carry_out, done, load_err
    );

endinterface

// File: rtl/modn_updown_counter_next_state.sv
// Wrap arithmetic for the mod-N counter: the neighbouring count in the
// requested direction and whether the current count is the terminal value
// for that direction. Works for moduli that are not powers of two.
module modn_next_state
    import modn_updown_counter_pkg::*;
#(
    parameter  int MODULUS = 7,
    localparam int WIDTH   = clog2_min1(MODULUS)
) (
    input  logic [WIDTH-1:0] count_i,
    input  logic             up_dn_i,
    output logic [WIDTH-1:0] next_o,
    output logic             at_term_o
);

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

    // Terminal is MODULUS-1 going up and 0 going down; step or wrap from there.
    always_comb begin
        // NOTE: outputs get a default first so no path through the case infers a latch.
        next_o    = count_i;
        at_term_o = 1'b0;
        case (up_dn_i)
            CNT_UP: begin
                at_term_o = (count_i == MAX_CNT);
                next_o    = at_term_o ? '0 : count_i + WIDTH'(1);
            end
            CNT_DN: begin
                at_term_o = (count_i == '0);
                next_o    = at_term_o ? MAX_CNT : count_i - WIDTH'(1);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/modn_updown_counter.sv
// Mod-N synchronous up/down counter with synchronous clear, clamped parallel
// load, enable, one-shot mode, terminal-count pulse and a cascade carry.
// Stages chain by feeding carry_out of one stage into en of the next.
module modn_updown_counter
    import modn_updown_counter_pkg::*;
#(
    parameter int MODULUS  = 7,
    parameter bit ONE_SHOT = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    modn_updown_counter_if.slave    bus
);

    localparam int               WIDTH   = clog2_min1(MODULUS);
    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q,    count_d;
    logic             tc_q,       tc_d;
    logic             done_q,     done_d;
    logic             load_err_q, load_err_d;
    logic             one_shot_q;

    logic [WIDTH-1:0] step_next;
    logic             at_term;
    logic             load_clamp;

    modn_next_state #(
        .MODULUS (MODULUS)
    ) u_next_state (
        .count_i   (count_q),
        .up_dn_i   (bus.up_dn),
        .next_o    (step_next),
        .at_term_o (at_term)
    );

    // The load value is compared in 32 bits so the check stays meaningful at any width.
    assign load_clamp = (32'(bus.load_val) > 32'(MODULUS - 1));

    // Cascade carry: this stage is about to leave its terminal value.
    assign bus.carry_out = bus.en & ~done_q & at_term;

    assign bus.count    = count_q;
    assign bus.tc       = tc_q;
    assign bus.done     = done_q;
    assign bus.load_err = load_err_q;

    // Next state with priority clr > load > enabled step; pulses default low.
    always_comb begin
        count_d    = count_q;
        tc_d       = 1'b0;
        done_d     = done_q;
        load_err_d = 1'b0;
        if (bus.clr) begin
            count_d = '0;
            done_d  = 1'b0;
        end else if (bus.load) begin
            count_d    = load_clamp ? MAX_CNT : bus.load_val;
            done_d     = 1'b0;
            load_err_d = load_clamp;
        end else if (bus.en && !done_q) begin
            if (at_term && one_shot_q) begin
                // One-shot stop: hold at terminal and flag completion once.
                done_d = 1'b1;
                tc_d   = 1'b1;
            end else begin
                count_d = step_next;
                tc_d    = at_term;
            end
        end
    end

    // State registers with asynchronous active-high reset; mode follows one_shot each edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= '0;
            tc_q       <= 1'b0;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
            one_shot_q <= ONE_SHOT;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            count_q    <= count_d;
            tc_q       <= tc_d;
            done_q     <= done_d;
            load_err_q <= load_err_d;
            one_shot_q <= bus.one_shot;
        end
    end

endmodule

// File: tb/tb_modn_updown_counter.sv
// Self-checking bench for modn_updown_counter: a vector table for the mod-7
// stage, plus hand sequences for cascading, other moduli and async reset.
module tb_modn_updown_counter;
    import modn_updown_counter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    modn_updown_counter_if #(.MODULUS(7))  bus  ();
    modn_updown_counter_if #(.MODULUS(2))  b2   ();
    modn_updown_counter_if #(.MODULUS(16)) b16  ();
    modn_updown_counter_if #(.MODULUS(10)) c_lo ();
    modn_updown_counter_if #(.MODULUS(10)) c_hi ();

    modn_updown_counter #(.MODULUS(7))  dut   (.clk(clk), .rst(rst), .bus(bus));
    modn_updown_counter #(.MODULUS(2))  dut2  (.clk(clk), .rst(rst), .bus(b2));
    modn_updown_counter #(.MODULUS(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));
    modn_updown_counter #(.MODULUS(10)) u_lo  (.clk(clk), .rst(rst), .bus(c_lo));
    modn_updown_counter #(.MODULUS(10)) u_hi  (.clk(clk), .rst(rst), .bus(c_hi));

    assign c_hi.en = c_lo.carry_out;

    typedef struct {
        logic       clr, load;
        logic [2:0] load_val;
        logic       en, up_dn, one_shot;
        logic [2:0] e_count;
        logic       e_tc, e_done, e_err, e_carry;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic clr, input logic load, input logic [2:0] lv,
                       input logic en, input logic ud, input logic os,
                       input logic [2:0] ec, input logic etc_, input logic ed,
                       input logic ee, input logic eca);
        vec_t v;
        v.clr = clr; v.load = load; v.load_val = lv;
        v.en = en; v.up_dn = ud; v.one_shot = os;
        v.e_count = ec; v.e_tc = etc_; v.e_done = ed; v.e_err = ee; v.e_carry = eca;
        vecs.push_back(v);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        bus.clr = v.clr; bus.load = v.load; bus.load_val = v.load_val;
        bus.en = v.en; bus.up_dn = v.up_dn; bus.one_shot = v.one_shot;
        #1;
        check($sformatf("v%0d carry_out", idx), bus.carry_out, v.e_carry);
        @(posedge clk);
        #1;
        check($sformatf("v%0d count", idx), bus.count, v.e_count);
        check($sformatf("v%0d tc", idx), bus.tc, v.e_tc);
        check($sformatf("v%0d done", idx), bus.done, v.e_done);
        check($sformatf("v%0d load_err", idx), bus.load_err, v.e_err);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " count"}, bus.count, 0);
        check({tag, " tc"}, bus.tc, 0);
        check({tag, " done"}, bus.done, 0);
        check({tag, " load_err"}, bus.load_err, 0);
    endtask

    task automatic set_idle(input logic en_all);
        bus.en = 1'b0; bus.up_dn = CNT_UP; bus.clr = 1'b0; bus.load = 1'b0;
        bus.load_val = '0; bus.one_shot = 1'b0;
        b2.en = en_all; b2.up_dn = CNT_UP; b2.clr = 1'b0; b2.load = 1'b0;
        b2.load_val = '0; b2.one_shot = 1'b0;
        b16.en = en_all; b16.up_dn = CNT_UP; b16.clr = 1'b0; b16.load = 1'b0;
        b16.load_val = '0; b16.one_shot = 1'b0;
        c_lo.en = en_all; c_lo.up_dn = CNT_UP; c_lo.clr = 1'b0; c_lo.load = 1'b0;
        c_lo.load_val = '0; c_lo.one_shot = 1'b0;
        c_hi.up_dn = CNT_UP; c_hi.clr = 1'b0; c_hi.load = 1'b0;
        c_hi.load_val = '0; c_hi.one_shot = 1'b0;
    endtask

    initial begin
        int hi_steps;
        int hi_tc;

        // Vector table for the mod-7 stage, starting from reset.
        for (int k = 1; k <= 10; k++)
            add(0, 0, 0, 1, CNT_UP, 0, 3'(k % 7), k == 7, 0, 0, k == 7);
        // Down from 0 after a clear.
        add(1, 0, 0, 0, CNT_UP, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, CNT_DN, 0, 6, 1, 0, 0, 1);
        add(0, 0, 0, 1, CNT_DN, 0, 5, 0, 0, 0, 0);
        add(0, 0, 0, 1, CNT_DN, 0, 4, 0, 0, 0, 0);
        // Loads, clamping, and clr/load overriding a wrap or direction flip.
        add(0, 1, 5, 0, CNT_UP, 0, 5, 0, 0, 0, 0);
        add(0, 1, 7, 0, CNT_UP, 0, 6, 0, 0, 1, 0);
        add(0, 0, 0, 0, CNT_UP, 0, 6, 0, 0, 0, 0);
        add(0, 1, 2, 1, CNT_UP, 0, 2, 0, 0, 0, 1);
        add(0, 1, 6, 0, CNT_UP, 0, 6, 0, 0, 0, 0);
        add(1, 0, 0, 1, CNT_UP, 0, 0, 0, 0, 0, 1);
        add(0, 1, 6, 0, CNT_UP, 0, 6, 0, 0, 0, 0);
        add(0, 0, 0, 1, CNT_DN, 0, 5, 0, 0, 0, 0);
        add(1, 1, 5, 0, CNT_UP, 0, 0, 0, 0, 0, 0);
        // One-shot from 4: stops at 6, single tc, sticky done until clr.
        add(0, 1, 4, 0, CNT_UP, 1, 4, 0, 0, 0, 0);
        add(0, 0, 0, 1, CNT_UP, 1, 5, 0, 0, 0, 0);
        add(0, 0, 0, 1, CNT_UP, 1, 6, 0, 0, 0, 0);
        add(0, 0, 0, 1, CNT_UP, 1, 6, 1, 1, 0, 1);
        add(0, 0, 0, 1, CNT_UP, 1, 6, 0, 1, 0, 0);
        add(0, 0, 0, 1, CNT_DN, 1, 6, 0, 1, 0, 0);
        add(0, 0, 0, 1, CNT_UP, 0, 6, 0, 1, 0, 0);
        add(0, 0, 0, 1, CNT_UP, 0, 6, 0, 1, 0, 0);
        add(1, 0, 0, 0, CNT_UP, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, CNT_UP, 0, 1, 0, 0, 0, 0);

        // Reset state, visible before any clock edge.
        set_idle(1'b0);
        #2;
        check_reset_state("reset");

        // Cascade of two mod-10 stages plus mod-2 / mod-16 free-run, all from reset.
        @(negedge clk);
        rst = 1'b0;
        set_idle(1'b1);
        hi_steps = 0;
        hi_tc    = 0;
        for (int k = 1; k <= 100; k++) begin
            #1;
            if (c_lo.carry_out === 1'b1) hi_steps++;
            @(posedge clk);
            #1;
            if (c_hi.tc === 1'b1) hi_tc++;
            if (k <= 20) begin
                check($sformatf("m2 count k%0d", k), b2.count, k % 2);
                check($sformatf("m2 tc k%0d", k), b2.tc, (k % 2) == 0);
                check($sformatf("m16 count k%0d", k), b16.count, k % 16);
                check($sformatf("m16 tc k%0d", k), b16.tc, (k % 16) == 0);
            end
            if (k == 55)
                check("cascade value at 55", c_hi.count * 10 + c_lo.count, 55);
            @(negedge clk);
        end
        check("cascade low final", c_lo.count, 0);
        check("cascade high final", c_hi.count, 0);
        check("cascade high steps", hi_steps, 10);
        check("cascade high tc pulses", hi_tc, 1);
        set_idle(1'b0);

        // Fresh reset, then the mod-7 vector table.
        rst = 1'b1;
        #1;
        check_reset_state("reset2");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < vecs.size(); i++)
            run_vec(vecs[i], i);

        // Asynchronous reset mid-count at 3, between edges.
        @(negedge clk);
        bus.en = 1'b1; bus.up_dn = CNT_UP;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("pre-rst count", bus.count, 3);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("async rst");
        @(posedge clk);
        #1;
        check("held in rst count", bus.count, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("first edge after rst", bus.count, 1);
        check("first edge after rst tc", bus.tc, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
